jal_imem_writer: RTL and testbench
==================================

# jal_imem_writer

Streaming JAL instruction encoder and instruction-memory writer; the producing end of the J-type decode path. It accepts (rd, byte offset) requests over a valid/ready handshake and packs each into a 32-bit RISC-V JAL word. It writes the words to consecutive instruction-memory addresses from 0 up to a fixed capacity. It sits between the test/boot loader logic and the instruction memory that the J-type decoder later reads.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 1024, capacity in words (DEPTH ≤ 2**ADDR_W)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready at a rising edge
- in_rd  input  5  destination register
- in_offset  input  21  signed byte offset, two's complement; bit 0 must be 0
- flush  input  1  synchronous restart: address, count, err cleared
- mem_we  output  1  write request to instruction memory
- mem_ready  input  1  memory accepts write when mem_we && mem_ready
- mem_addr  output  ADDR_W  word address of current write
- mem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  words written (accepted by memory) since reset/flush
- full  output  1  count == DEPTH
- err  output  1  sticky: misaligned offset seen (only with macro)

## Operation
- Encoding: wdata[31]=off[20], [30:21]=off[10:1], [20]=off[11], [19:12]=off[19:12], [11:7]=rd, [6:0]=7'b1101111 (JAL). off[0] is never encoded.
- States: RUN, FULL.
- RUN:
  - in_ready = !full_pending && (!mem_we || mem_ready) && !flush.
  - Accepted request loads the output register: mem_we=1, mem_wdata=encoding, mem_addr=next_addr.
- Write completion (mem_we && mem_ready):
  - count += 1; next_addr += 1.
  - If a new request is accepted in the same cycle, mem_we stays 1 with the new word and address (back-to-back, one word/cycle).
- Backpressure: while mem_we && !mem_ready, mem_we/mem_addr/mem_wdata are held stable and in_ready=0.
- RUN→FULL when the write that makes count == DEPTH completes.
  - Once DEPTH requests have been accepted, in_ready is 0 (full_pending).
- FULL:
  - full=1, in_ready=0, mem_we=0.
  - Leaves only via flush or reset.
- flush (any state):
  - Has priority over everything.
  - Pending un-accepted write is discarded: mem_we=0.
  - next_addr=0, count=0, err=0, state=RUN.
  - in_ready=0 during the flush cycle.
- Address never wraps; max mem_addr = DEPTH-1.
- rd=0 is legal (plain J).

## Timing
- Reset (async assert, sync-safe deassert): mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, state=RUN.
  - in_ready=1 from the first edge after deassert.
- Latency: a request accepted at edge N drives mem_we/mem_wdata from after edge N (visible cycle N+1).
- Throughput: 1 word/cycle with mem_ready held high.
- Reset mid-write: the write is abandoned immediately, with no partial state kept.

## Configuration
- JAL_ALIGN_CHECK_EN defined:
  - An accepted request with in_offset[0]=1 is consumed but not written.
  - mem_we, count and next_addr are unchanged; err is set sticky.
- Undefined:
  - err is tied to 0.
  - off[0] is ignored and every accepted request is written.

## Structure
- Shared package jal_pkg:
  - JAL_OPCODE constant (7'b1101111)
  - state enum {RUN, FULL}
  - field-position constants for the J-immediate scatter
- Sub-module jal_encode: purely combinational (rd, offset) → 32-bit word packer, reusable by bench reference models.
- The top holds the handshake, output register, address/count counters and FSM.

## Test plan
- rd=1, offset=+8 after reset → mem_we next cycle, mem_addr=0, mem_wdata=0x008000EF; count=1 after mem_ready.
- rd=0, offset=21'h1FFFFC (−4) → mem_wdata=0xFFDFF06F.
- mem_ready low 3 cycles with second request waiting:
  - mem_addr/mem_wdata stable, in_ready=0.
  - On release, back-to-back writes to addr 0 then 1.
- DEPTH=4, six requests with mem_ready=1:
  - Writes go to addr 0..3 only; full=1, in_ready=0.
  - flush → count=0, full=0, the next write lands at addr 0.
- offset=21'h000003, rd=0:
  - With JAL_ALIGN_CHECK_EN: no write, err=1, count unchanged.
  - Without: write 0x0020006F.
- rst_n asserted low while mem_we=1 and mem_ready=0 → all outputs 0 immediately; after release the first write goes to addr 0.

Source files
------------

// File: rtl/jal_pkg.sv
// Shared constants for the JAL encode/write path: opcode, writer states and
// bit positions of the J-immediate scatter inside the 32-bit instruction word.
package jal_pkg;

    localparam logic [6:0] JAL_OPCODE = 7'b1101111;

    typedef enum logic {
        RUN  = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int RD_LSB       = 7;
    localparam int IMM19_12_LSB = 12;
    localparam int IMM11_BIT    = 20;
    localparam int IMM10_1_LSB  = 21;
    localparam int IMM20_BIT    = 31;

endpackage

// File: rtl/jal_imem_writer_if.sv
// Request channel (rd/offset in) and instruction-memory write channel of the
// JAL writer; slave is the writer side, master the loader/memory side.
interface jal_imem_writer_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic [20:0]       in_offset;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_rd, in_offset, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_rd, in_offset, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/jal_imem_writer_encode.sv
// Combinational packer of (rd, byte offset) into a RISC-V JAL instruction word.
// Offset bit 0 has no slot in the J-immediate and is dropped.
module jal_encode
    import jal_pkg::*;
(
    input  logic [4:0]  rd,
    input  logic [20:0] offset,
    output logic [31:0] word
);
    logic unused_off_bit0;
    assign unused_off_bit0 = offset[0];

    always_comb begin
        word                       = '0;
        word[6:0]                  = JAL_OPCODE;
        word[RD_LSB +: 5]          = rd;
        word[IMM19_12_LSB +: 8]    = offset[19:12];
        word[IMM11_BIT]            = offset[11];
        word[IMM10_1_LSB +: 10]    = offset[10:1];
        word[IMM20_BIT]            = offset[20];
    end
endmodule

// File: rtl/jal_imem_writer.sv
// Streams JAL words into instruction memory at addresses 0..DEPTH-1.
// Define JAL_ALIGN_CHECK_EN to drop odd-offset requests and flag them on err.
//
// state | meaning
// RUN   | accepting requests, at most one write outstanding
// FULL  | DEPTH words written; idle until flush or reset
module jal_imem_writer
    import jal_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    jal_imem_writer_if.slave  bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              live;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] next_addr;
    logic              full_pending;
    logic              accept;
    logic              done;
    logic              misaligned;

    jal_encode u_encode (
        .rd     (bus.in_rd),
        .offset (bus.in_offset),
        .word   (enc_word)
    );

    // Words written plus the one in flight; the write address tracks count.
    assign next_addr    = count[ADDR_W-1:0];
    assign full_pending = (count + {{ADDR_W{1'b0}}, bus.mem_we}) >= DEPTH_C;
    assign done         = bus.mem_we && bus.mem_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign full         = (state == FULL);

    assign bus.in_ready = live && (state == RUN) && !full_pending &&
                          (!bus.mem_we || bus.mem_ready) && !flush;

`ifdef JAL_ALIGN_CHECK_EN
    assign misaligned = bus.in_offset[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (flush) begin
            err <= 1'b0;
        end else if (accept && misaligned) begin
            err <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            live          <= 1'b0;
            count         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                state      <= RUN;
                count      <= '0;
                bus.mem_we <= 1'b0;
            end else begin
                if (done) begin
                    count <= count + (ADDR_W + 1)'(1);
                    if (count + (ADDR_W + 1)'(1) == DEPTH_C) begin
                        state <= FULL;
                    end
                end
                if (accept && !misaligned) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_wdata <= enc_word;
                    bus.mem_addr  <= done ? next_addr + ADDR_W'(1) : next_addr;
                end else if (done) begin
                    bus.mem_we <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jal_imem_writer.sv
// Bench for jal_imem_writer: directed scenarios then random traffic, all checked
// against a transaction-level model (words written, one pending word, err flag).
module tb_jal_imem_writer;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [ADDR_W:0] count;
    logic            full;
    logic            err;

    jal_imem_writer_if #(.ADDR_W(ADDR_W)) bus ();

    jal_imem_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_written;
    bit          m_pend;
    logic [31:0] m_word;
    int          m_addr;
    bit          m_err;
    bit          m_live;

`ifdef JAL_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] jal_word(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
    endfunction

    task automatic model_reset();
        m_written = 0;
        m_pend    = 1'b0;
        m_word    = '0;
        m_addr    = 0;
        m_err     = 1'b0;
        m_live    = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [4:0] rd, input logic [20:0] off,
                        input bit mr, input bit fl);
        bit exp_rdy;
        bus.in_valid  = v;
        bus.in_rd     = rd;
        bus.in_offset = off;
        bus.mem_ready = mr;
        flush         = fl;
        #1;
        exp_rdy = m_live && !fl && (m_written + int'(m_pend) < DEPTH) && (!m_pend || mr);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("mem_we", 32'(bus.mem_we), 32'(m_pend));
        if (m_pend) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("mem_wdata", bus.mem_wdata, m_word);
        end
        chk("count", 32'(count), 32'(m_written));
        chk("full", 32'(full), 32'(m_written == DEPTH));
        chk("err", 32'(err), 32'(m_err));
        if (fl) begin
            m_written = 0;
            m_pend    = 1'b0;
            m_err     = 1'b0;
        end else begin
            if (m_pend && mr) begin
                m_written++;
                m_pend = 1'b0;
            end
            if (v && exp_rdy) begin
                if (ALIGN_CHK && off[0]) begin
                    m_err = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_word = jal_word(rd, off);
                    m_addr = m_written;
                end
            end
        end
        @(posedge clk);
        m_live = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [20:0] off;
        bus.in_valid  = 1'b0;
        bus.in_rd     = '0;
        bus.in_offset = '0;
        bus.mem_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // first request and the -4 encoding
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b0);
        step(1'b1, 5'd1, 21'd8, 1'b0, 1'b0);
        chk("enc_plus8", bus.mem_wdata, 32'h008000EF);
        chk("first_addr", 32'(bus.mem_addr), 32'd0);
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b0);
        chk("count_after_first", 32'(count), 32'd1);
        step(1'b1, 5'd0, 21'h1FFFFC, 1'b1, 1'b0);
        chk("enc_minus4", bus.mem_wdata, 32'hFFDFF06F);

        // backpressure with a second request waiting, then back-to-back
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b1);
        step(1'b1, 5'd3, 21'd16, 1'b1, 1'b0);
        repeat (3) step(1'b1, 5'd4, 21'd20, 1'b0, 1'b0);
        chk("stall_addr", 32'(bus.mem_addr), 32'd0);
        chk("stall_wdata", bus.mem_wdata, jal_word(5'd3, 21'd16));
        step(1'b1, 5'd4, 21'd20, 1'b1, 1'b0);
        chk("b2b_addr", 32'(bus.mem_addr), 32'd1);
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b0);
        chk("b2b_count", 32'(count), 32'd2);

        // fill to capacity and beyond, then flush
        repeat (6) step(1'b1, 5'($urandom), 21'($urandom) & 21'h1FFFFE, 1'b1, 1'b0);
        chk("fill_count", 32'(count), 32'(DEPTH));
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 5'd7, 21'd4, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        step(1'b1, 5'd9, 21'd40, 1'b1, 1'b0);
        chk("post_flush_addr", 32'(bus.mem_addr), 32'd0);

        // odd offset
        step(1'b1, 5'd0, 21'h000003, 1'b1, 1'b0);
`ifdef JAL_ALIGN_CHECK_EN
        chk("odd_no_write", 32'(bus.mem_we), 32'd0);
        chk("odd_err", 32'(err), 32'd1);
        chk("odd_count", 32'(count), 32'd1);
`else
        chk("odd_wdata", bus.mem_wdata, 32'h0020006F);
        chk("odd_err", 32'(err), 32'd0);
`endif

        // reset while a write is stalled
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b1);
        step(1'b1, 5'd5, 21'd8, 1'b0, 1'b0);
        step(1'b1, 5'd6, 21'd12, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        release_reset();
        step(1'b0, 5'd0, 21'd0, 1'b1, 1'b0);
        step(1'b1, 5'd6, 21'd12, 1'b1, 1'b0);
        chk("post_rst_addr", 32'(bus.mem_addr), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            off = 21'($urandom) & 21'h1FFFFE;
            if ($urandom_range(7) == 0) off[0] = 1'b1;
            step($urandom_range(9) < 7, 5'($urandom), off,
                 $urandom_range(9) < 7, $urandom_range(29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
